ifetch_responder: RTL

- Instruction-memory responder on the far end of the Fetch unit's fetch path.
- Accepts PC fetch requests and returns one 60-bit VLIW-2 bundle per request: two 30-bit instruction slots, lower-addressed slot in bits [29:0].
- Pipelined synchronous read with programmable latency, in-order responses, and an output skid FIFO with credit-based backpressure.
- flushBack_i discards all in-flight work so the core can redirect after a branch.

---
 rtl/ifetch_responder_if.sv | 25 ++
 rtl/ifetch_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/ifetch_responder_if.sv
// Fetch-path handshake between the Fetch unit (master) and the instruction-memory responder (slave).
interface ifetch_responder_if #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned BUNDLE_W = 60
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [ADDR_W-1:0]   req_pc_i;
    logic                flushBack_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    logic [BUNDLE_W-1:0] resp_data_o;
    logic [ADDR_W-1:0]   resp_pc_o;
    logic                resp_fault_o;

    modport master (
        output req_valid_i, req_pc_i, flushBack_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_pc_o, resp_fault_o
    );

    modport slave (
        input  req_valid_i, req_pc_i, flushBack_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_pc_o, resp_fault_o
    );
endinterface

// File: rtl/ifetch_responder.sv
// Instruction-memory responder: pipelined bundle read, in-order skid FIFO, credit backpressure,
// flush of all in-flight work, and an independent memory load port.
module ifetch_responder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned BUNDLE_W   = 60,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned Q_DEPTH    = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    ifetch_responder_if.slave     fetch,
    input  logic                  ld_en_i,
    input  logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  logic [BUNDLE_W-1:0]   ld_data_i
);
    localparam int unsigned QW        = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CW        = $clog2(Q_DEPTH + 1);
    localparam int unsigned MEM_DEPTH = 1 << DEPTH_LOG2;

    logic [BUNDLE_W-1:0] mem [MEM_DEPTH];

    logic [LATENCY-1:0]               stValid;
    logic [LATENCY-1:0]               stFault;
    logic [LATENCY-1:0][ADDR_W-1:0]   stPc;
    logic [LATENCY-1:0][BUNDLE_W-1:0] stData;

    logic [BUNDLE_W-1:0] fifoData  [Q_DEPTH];
    logic [ADDR_W-1:0]   fifoPc    [Q_DEPTH];
    logic                fifoFault [Q_DEPTH];
    logic [QW-1:0]       wrPtr;
    logic [QW-1:0]       rdPtr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       credit;

    logic                  flush;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  reqFault;
    logic [DEPTH_LOG2-1:0] reqIdx;

    function automatic logic [QW-1:0] nextPtr(input logic [QW-1:0] p);
        return (p == QW'(Q_DEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    assign flush    = fetch.flushBack_i;
    assign reqIdx   = fetch.req_pc_i[DEPTH_LOG2-1:0];
    assign reqFault = |fetch.req_pc_i[ADDR_W-1:DEPTH_LOG2];

    // Credit covers in-flight plus queued entries, so the FIFO can never overflow.
    assign fetch.req_ready_o = reset_i && !flush && (credit < CW'(Q_DEPTH));
    assign accept            = fetch.req_valid_i && fetch.req_ready_o;
    assign push              = stValid[LATENCY-1] && !flush;
    assign pop               = fetch.resp_valid_o && fetch.resp_ready_i && !flush;

    assign fetch.resp_valid_o = (count != '0);
    assign fetch.resp_data_o  = fifoData[rdPtr];
    assign fetch.resp_pc_o    = fifoPc[rdPtr];
    assign fetch.resp_fault_o = fifoFault[rdPtr];

    // Data path carries no reset: the read is captured every cycle and qualified by stValid.
    always_ff @(posedge clock_i) begin
        if (ld_en_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
        stData[0] <= reqFault ? '0 : mem[reqIdx];
        for (int unsigned k = 1; k < LATENCY; k++) begin
            stData[k] <= stData[k-1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stValid <= '0;
            stFault <= '0;
            stPc    <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            credit  <= '0;
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                fifoData[i]  <= '0;
                fifoPc[i]    <= '0;
                fifoFault[i] <= 1'b0;
            end
        end else if (flush) begin
            stValid <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            credit  <= '0;
        end else begin
            stValid[0] <= accept;
            stPc[0]    <= fetch.req_pc_i;
            stFault[0] <= reqFault;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                stValid[k] <= stValid[k-1];
                stPc[k]    <= stPc[k-1];
                stFault[k] <= stFault[k-1];
            end

            if (push) begin
                fifoData[wrPtr]  <= stData[LATENCY-1];
                fifoPc[wrPtr]    <= stPc[LATENCY-1];
                fifoFault[wrPtr] <= stFault[LATENCY-1];
                wrPtr            <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end

            count  <= count + CW'(push) - CW'(pop);
            credit <= credit + CW'(accept) - CW'(pop);
        end
    end
endmodule
